// File: rtl/jp2k_frame_ctrl.sv
// Per-image sequencer for the JPEG2000 core: reset hold, start pulse, byte
// accounting, completion detection and watchdog, all from registered state.
module jp2k_frame_ctrl #(
   parameter int RST_HOLD       = 8,
   parameter int TIMEOUT_CYCLES = 16000000,
   parameter int FRAME_CNT_W    = 16
) (
   input  logic                   clk_dwt,
   input  logic                   rst,
   input  logic                   host_start,
   input  logic [2:0]             host_ratio,
   input  logic                   host_abort,
   input  logic                   one_image_over,
   input  logic [3:0]             write_en,
   output logic                   core_rst,
   output logic                   start_cpu,
   output logic [2:0]             compression_ratio,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic [31:0]            bytes_written,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);
   localparam logic [23:0] WD_LAST   = 24'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PRERST, START, RUN, DONE, ABORT} state_t;

   state_t      state;
   logic [7:0]  hold;
   logic [23:0] wdog;
   logic        oio_q;
   logic [31:0] byte_cnt;
   logic [2:0]  pop;
   logic [32:0] byte_sum;
   logic        oio_rise;

   always_comb begin
      pop      = 3'(write_en[0]) + 3'(write_en[1]) + 3'(write_en[2]) + 3'(write_en[3]);
      byte_sum = {1'b0, byte_cnt} + 33'(pop);
      oio_rise = one_image_over & ~oio_q;
   end

   assign bytes_written = byte_cnt;

   always_ff @(posedge clk_dwt or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         hold              <= '0;
         wdog              <= '0;
         oio_q             <= 1'b0;
         byte_cnt          <= '0;
         core_rst          <= 1'b0;
         start_cpu         <= 1'b0;
         compression_ratio <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         timeout_err       <= 1'b0;
         frame_count       <= '0;
      end else begin
         oio_q     <= one_image_over;
         start_cpu <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               core_rst <= 1'b1;
               busy     <= 1'b0;
               if (host_start) begin
                  compression_ratio <= host_ratio;
                  byte_cnt          <= '0;
                  timeout_err       <= 1'b0;
                  wdog              <= '0;
                  hold              <= '0;
                  core_rst          <= 1'b0;
                  busy              <= 1'b1;
                  state             <= PRERST;
               end
            end
            PRERST: begin
               // an abort before RUN simply restarts the hold as an abort hold
               if (host_abort) begin
                  hold  <= '0;
                  state <= ABORT;
               end else if (hold == HOLD_LAST) begin
                  start_cpu <= 1'b1;
                  core_rst  <= 1'b1;
                  state     <= START;
               end else begin
                  hold <= hold + 8'd1;
               end
            end
            START: begin
               if (host_abort) begin
                  hold     <= '0;
                  core_rst <= 1'b0;
                  state    <= ABORT;
               end else begin
                  wdog  <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               byte_cnt <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
               wdog     <= wdog + 24'd1;
               if (host_abort) begin
                  hold     <= '0;
                  core_rst <= 1'b0;
                  state    <= ABORT;
               end else if (oio_rise) begin
                  done        <= 1'b1;
                  frame_count <= frame_count + FRAME_CNT_W'(1);
                  state       <= DONE;
               end else if (wdog == WD_LAST) begin
                  timeout_err <= 1'b1;
                  hold        <= '0;
                  core_rst    <= 1'b0;
                  state       <= ABORT;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            ABORT: begin
               if (hold == HOLD_LAST) begin
                  core_rst <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  hold <= hold + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jp2k_frame_ctrl.sv
// Bench for jp2k_frame_ctrl: table-driven normal frame, directed corner
// sequences, then random traffic against a timeline-based reference model.
module tb_jp2k_frame_ctrl;
   localparam int RH = 4;
   localparam int TO = 20;
   localparam int FW = 4;

   logic          clk_dwt = 1'b0;
   logic          rst = 1'b1;
   logic          host_start = 1'b0, host_abort = 1'b0, one_image_over = 1'b0;
   logic [2:0]    host_ratio = '0;
   logic [3:0]    write_en = '0;
   logic          core_rst, start_cpu, busy, done, timeout_err;
   logic [2:0]    compression_ratio;
   logic [31:0]   bytes_written;
   logic [FW-1:0] frame_count;

   jp2k_frame_ctrl #(.RST_HOLD(RH), .TIMEOUT_CYCLES(TO), .FRAME_CNT_W(FW)) dut (
      .clk_dwt(clk_dwt), .rst(rst), .host_start(host_start), .host_ratio(host_ratio),
      .host_abort(host_abort), .one_image_over(one_image_over), .write_en(write_en),
      .core_rst(core_rst), .start_cpu(start_cpu), .compression_ratio(compression_ratio),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .bytes_written(bytes_written), .frame_count(frame_count));

   always #5 clk_dwt = ~clk_dwt;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a frame is a timeline measured from the accepting edge.
   // mode 0 idle, 1 frame in progress, 2 completion edge, 3 abort hold.
   int       cyc, mode, n0, a0;
   bit       m_core_rst, m_start, m_busy, m_done, m_terr, m_oio_prev;
   bit [2:0] m_ratio;
   longint   m_bytes;
   int       m_fc;

   function automatic void model_reset();
      mode = 0; m_core_rst = 0; m_start = 0; m_busy = 0; m_done = 0; m_terr = 0;
      m_oio_prev = 0; m_ratio = 0; m_bytes = 0; m_fc = 0;
   endfunction

   function automatic bit model_next_is_run();
      return mode == 1 && (cyc + 1 - n0) >= RH + 2;
   endfunction

   function automatic void model_edge();
      int k;
      bit rise;
      cyc++;
      rise = one_image_over && !m_oio_prev;
      case (mode)
         0: if (host_start) begin
               n0 = cyc; m_ratio = host_ratio; m_bytes = 0; m_terr = 0; mode = 1;
            end
         1: begin
               k = cyc - n0;
               if (k >= RH + 2) begin
                  m_bytes += $countones(write_en);
                  if (m_bytes > 64'hFFFF_FFFF) m_bytes = 64'hFFFF_FFFF;
                  if (host_abort) begin mode = 3; a0 = cyc; end
                  else if (rise) begin mode = 2; m_fc = (m_fc + 1) % (1 << FW); end
                  else if (k - (RH + 2) == TO - 1) begin m_terr = 1; mode = 3; a0 = cyc; end
               end
            end
         2: mode = 0;
         default: if (cyc - a0 == RH) mode = 0;
      endcase
      m_oio_prev = one_image_over;
      m_start = 0; m_done = 0;
      case (mode)
         0: begin m_core_rst = 1; m_busy = 0; end
         1: begin
               k = cyc - n0;
               m_core_rst = (k >= RH); m_start = (k == RH); m_busy = 1;
            end
         2: begin m_core_rst = 1; m_busy = 1; m_done = 1; end
         default: begin m_core_rst = 0; m_busy = 1; end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_dwt);
      model_edge();
      #1;
   endtask

   task automatic start_frame(input logic [2:0] r);
      host_start = 1'b1; host_ratio = r;
      tick();
      host_start = 1'b0;
      chk("start busy", busy, 1);
      chk("start clears timeout_err", timeout_err, 0);
      repeat (RH + 1) tick();
   endtask

   typedef struct {
      logic hs; logic [2:0] hr; logic [3:0] we; logic oio; logic ab;
      logic e_crst, e_start, e_busy, e_done;
      logic [31:0] e_bytes; logic [FW-1:0] e_fc; logic [2:0] e_ratio;
   } vec_t;
   vec_t tbl[$];

   function automatic void addv(logic hs, logic [2:0] hr, logic [3:0] we, logic oio,
                                logic crst, logic st, logic bz, logic dn,
                                logic [31:0] by, logic [FW-1:0] fc);
      vec_t v;
      v.hs = hs; v.hr = hr; v.we = we; v.oio = oio; v.ab = 1'b0;
      v.e_crst = crst; v.e_start = st; v.e_busy = bz; v.e_done = dn;
      v.e_bytes = by; v.e_fc = fc; v.e_ratio = 3'd3;
      tbl.push_back(v);
   endfunction

   initial begin
      bit saw_done;
      cyc = 0; n0 = 0; a0 = 0;
      model_reset();

      // normal frame timeline, RST_HOLD=4
      addv(1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
      repeat (3) addv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      addv(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
      addv(0, 0, 4'hF, 0, 1, 0, 1, 0, 0, 0);  // START->RUN edge: strobes not counted
      for (int i = 1; i <= 10; i++) addv(0, 0, 4'hF, 0, 1, 0, 1, 0, 32'(4 * i), 0);
      for (int i = 1; i <= 5; i++)  addv(0, 0, 4'h3, 0, 1, 0, 1, 0, 32'(40 + 2 * i), 0);
      addv(0, 0, 0, 1, 1, 0, 1, 1, 50, 1);
      addv(0, 0, 0, 1, 1, 0, 0, 0, 50, 1);

      // reset values
      #1 rst = 1'b0;
      #1;
      chk("reset core_rst", core_rst, 0);
      chk("reset busy", busy, 0);
      chk("reset bytes", bytes_written, 0);
      chk("reset frame_count", frame_count, 0);
      chk("reset ratio", compression_ratio, 0);
      #1 rst = 1'b1;
      tick();
      chk("first edge core_rst", core_rst, 1);
      chk("first edge busy", busy, 0);

      foreach (tbl[i]) begin
         host_start = tbl[i].hs; host_ratio = tbl[i].hr; write_en = tbl[i].we;
         one_image_over = tbl[i].oio; host_abort = tbl[i].ab;
         tick();
         chk($sformatf("t1[%0d] core_rst", i), core_rst, tbl[i].e_crst);
         chk($sformatf("t1[%0d] start_cpu", i), start_cpu, tbl[i].e_start);
         chk($sformatf("t1[%0d] busy", i), busy, tbl[i].e_busy);
         chk($sformatf("t1[%0d] done", i), done, tbl[i].e_done);
         chk($sformatf("t1[%0d] bytes", i), bytes_written, tbl[i].e_bytes);
         chk($sformatf("t1[%0d] frame_count", i), frame_count, tbl[i].e_fc);
         chk($sformatf("t1[%0d] ratio", i), compression_ratio, tbl[i].e_ratio);
      end
      one_image_over = 0; write_en = 0;

      // timeout exactly TO cycles after RUN entry
      start_frame(3'd1);
      repeat (TO - 1) tick();
      chk("t2 timeout before limit", timeout_err, 0);
      tick();
      chk("t2 timeout_err", timeout_err, 1);
      chk("t2 core_rst low", core_rst, 0);
      repeat (RH - 1) tick();
      chk("t2 hold core_rst", core_rst, 0);
      chk("t2 hold busy", busy, 1);
      tick();
      chk("t2 idle busy", busy, 0);
      chk("t2 idle core_rst", core_rst, 1);
      chk("t2 frame_count", frame_count, 1);
      chk("t2 sticky", timeout_err, 1);
      host_abort = 1; tick(); host_abort = 0;
      chk("t2 abort in idle", busy, 0);

      // abort coincident with completion edge: abort wins
      start_frame(3'd1);
      repeat (2) tick();
      host_abort = 1; one_image_over = 1;
      tick();
      host_abort = 0;
      chk("t3 abort done", done, 0);
      chk("t3 abort core_rst", core_rst, 0);
      saw_done = 0;
      repeat (RH) begin tick(); saw_done |= done; end
      chk("t3 no done pulse", saw_done, 0);
      chk("t3 abort idle busy", busy, 0);
      chk("t3 frame_count", frame_count, 1);
      one_image_over = 0;

      // completion on the final watchdog cycle
      start_frame(3'd1);
      repeat (TO - 1) tick();
      one_image_over = 1;
      tick();
      chk("t3 last-cycle done", done, 1);
      chk("t3 last-cycle timeout_err", timeout_err, 0);
      chk("t3 last-cycle frame_count", frame_count, 2);
      tick();
      chk("t3 busy drop", busy, 0);
      chk("t3 done one cycle", done, 0);
      one_image_over = 0;

      // level already high before START is not a completion
      one_image_over = 1;
      tick();
      start_frame(3'd2);
      saw_done = 0;
      repeat (5) begin tick(); saw_done |= done; end
      chk("t4 stale level", saw_done, 0);
      chk("t4 still busy", busy, 1);
      one_image_over = 0; tick();
      one_image_over = 1; tick();
      chk("t4 fresh edge done", done, 1);
      chk("t4 frame_count", frame_count, 3);
      tick();
      one_image_over = 0;

      // host_start ignored mid-frame; byte counter saturation
      start_frame(3'd2);
      host_start = 1; host_ratio = 3'd5;
      tick();
      host_start = 0;
      chk("t5 ratio held", compression_ratio, 2);
      chk("t5 busy", busy, 1);
      force dut.byte_cnt = 32'hFFFF_FFF6;
      #1 release dut.byte_cnt;
      m_bytes = 64'hFFFF_FFF6;
      write_en = 4'hF;
      tick(); chk("t5 bytes +4", bytes_written, 32'hFFFF_FFFA);
      tick(); chk("t5 bytes +8", bytes_written, 32'hFFFF_FFFE);
      tick(); chk("t5 bytes sat", bytes_written, 32'hFFFF_FFFF);
      tick(); chk("t5 bytes sat hold", bytes_written, 32'hFFFF_FFFF);
      write_en = 0; one_image_over = 1;
      tick(); tick();
      one_image_over = 0;
      write_en = 4'hF; tick(); write_en = 0;
      chk("t5 idle not counted", bytes_written, 32'hFFFF_FFFF);

      // async reset mid-RUN
      start_frame(3'd6);
      write_en = 4'hF;
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("t6 core_rst", core_rst, 0);
      chk("t6 start_cpu", start_cpu, 0);
      chk("t6 ratio", compression_ratio, 0);
      chk("t6 busy", busy, 0);
      chk("t6 done", done, 0);
      chk("t6 timeout_err", timeout_err, 0);
      chk("t6 bytes", bytes_written, 0);
      chk("t6 frame_count", frame_count, 0);
      #2 rst = 1'b1;
      write_en = 0;
      tick();
      chk("t6 release core_rst", core_rst, 1);
      chk("t6 release busy", busy, 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         host_start = ($urandom_range(5) == 0);
         host_ratio = 3'($urandom);
         write_en   = 4'($urandom);
         if ($urandom_range(4) == 0) one_image_over = ~one_image_over;
         host_abort = model_next_is_run() && ($urandom_range(39) == 0);
         tick();
         chk($sformatf("rnd[%0d] core_rst", i), core_rst, m_core_rst);
         chk($sformatf("rnd[%0d] start_cpu", i), start_cpu, m_start);
         chk($sformatf("rnd[%0d] busy", i), busy, m_busy);
         chk($sformatf("rnd[%0d] done", i), done, m_done);
         chk($sformatf("rnd[%0d] timeout_err", i), timeout_err, m_terr);
         chk($sformatf("rnd[%0d] ratio", i), compression_ratio, m_ratio);
         chk($sformatf("rnd[%0d] bytes", i), bytes_written, m_bytes[31:0]);
         chk($sformatf("rnd[%0d] frame_count", i), frame_count, m_fc[FW-1:0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/jp2k_frame_ctrl.md
# jp2k_frame_ctrl

Per-image sequencer for the JPEG2000 encoder core. It accepts a frame request from the host and latches the compression ratio. It then resets the core and pulses `start_cpu`, and monitors tier-2 `write_en` and `one_image_over` to report byte count, completion and timeout. It sits between the host/CPU interface and `jpeg2000_top` and drives that core's reset, start and ratio inputs.

## Interface
- `RST_HOLD`, default 8: cycles `core_rst` is held low before each frame and after abort or timeout; legal range 1..255.
- `TIMEOUT_CYCLES`, default 16000000: watchdog limit, in cycles spent in RUN; legal range 2..2^24-1.
- `FRAME_CNT_W`, default 16: width of `frame_count`.
- `clk_dwt` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `host_start` in 1: frame request, sampled only in IDLE.
- `host_ratio` in 3: compression ratio, latched when `host_start` is accepted.
- `host_abort` in 1: abort the current frame, level, sampled every cycle.
- `one_image_over` in 1: core completion, level; its rising edge is used.
- `write_en` in 4: tier-2 byte-lane write strobes.
- `core_rst` out 1: active-low reset to the core.
- `start_cpu` out 1: one-cycle start pulse to the core.
- `compression_ratio` out 3: latched ratio to the core.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on frame completion.
- `timeout_err` out 1: sticky; set by watchdog expiry.
- `bytes_written` out 32: bytes written during the current or last frame.
- `frame_count` out `FRAME_CNT_W`: number of completed frames.

## Operation
- States: IDLE, PRERST, START, RUN, DONE, ABORT. All outputs are registered.
- IDLE
  - `core_rst`=1, `busy`=0.
  - On `host_start`=1:
    - latch `host_ratio` into `compression_ratio`;
    - clear `bytes_written`, `timeout_err` and the watchdog;
    - go to PRERST.
  - `host_abort` has no effect in IDLE.
- PRERST: `core_rst`=0 for exactly `RST_HOLD` cycles (hold counter), then go to START.
- START: `start_cpu`=1 for this one cycle, `core_rst`=1; go to RUN.
- RUN
  - Each cycle, add popcount(`write_en`) (0..4) to `bytes_written`, saturating at 0xFFFFFFFF.
  - The watchdog increments each cycle.
  - Priority, highest first:
    1. `host_abort`: go to ABORT.
    2. Rising edge of `one_image_over` (input=1 and previous-cycle sample=0): go to DONE.
    3. Watchdog == `TIMEOUT_CYCLES`-1: set `timeout_err`, go to ABORT.
  - Completion and watchdog expiry in the same cycle: completion wins and `timeout_err` stays 0.
- DONE
  - `done`=1 for one cycle.
  - `frame_count` increments, wrapping modulo 2^`FRAME_CNT_W`.
  - Go to IDLE.
- ABORT
  - `core_rst`=0 for `RST_HOLD` cycles, then go to IDLE.
  - `frame_count` is not incremented and `done` is not pulsed.
  - `bytes_written` retains its value.
- The `one_image_over` edge-detect register is updated every cycle in all states. A level that is already high when RUN is entered does not count as completion.
- `host_start` outside IDLE is ignored (not queued). `host_ratio` changes outside IDLE are ignored.
- `write_en` outside RUN is not counted.
- The hold counter is 8 bits and the watchdog is 24 bits; both are cleared on entry to their state.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE;
  - `core_rst`=0 (core held in reset);
  - `start_cpu`=0, `compression_ratio`=0, `busy`=0, `done`=0, `timeout_err`=0, `bytes_written`=0, `frame_count`=0.
- After reset release, `core_rst` rises on the first clock edge.
- Frame start, with `host_start` sampled high in IDLE at edge N:
  - `busy`=1 and `core_rst`=0 from N+1 through N+`RST_HOLD`;
  - `start_cpu`=1 during cycle N+`RST_HOLD`+1;
  - RUN from N+`RST_HOLD`+2.
- Completion: a rising edge of `one_image_over` sampled at edge M gives `done`=1 and incremented `frame_count` in cycle M+1, then `busy`=0 from M+2.
- The `write_en` sample at edge M is included in `bytes_written`.
- Abort or timeout at edge M: `core_rst`=0 from M+1 through M+`RST_HOLD`, then `busy`=0 at M+`RST_HOLD`+1. `timeout_err` is visible from M+1.
- An asynchronous reset mid-frame returns to IDLE immediately, with all outputs at reset values.

## Test plan
1. Reset then normal frame (`RST_HOLD`=4): `host_start` with `host_ratio`=3 -> `core_rst` low 4 cycles, one `start_cpu` pulse, `compression_ratio`=3. Apply `write_en`=4'b1111 ×10 and 4'b0011 ×5, then raise `one_image_over` -> `bytes_written`=50, one-cycle `done`, `frame_count`=1, `busy` drops the next cycle.
2. Timeout (`TIMEOUT_CYCLES`=20) with no completion -> `timeout_err`=1 exactly 20 cycles after RUN entry, `core_rst` low 4 cycles, `frame_count` unchanged. The next `host_start` clears `timeout_err`.
3. Abort and `one_image_over` edge in the same RUN cycle -> ABORT taken, no `done`, `frame_count` unchanged. Completion coincident with the last watchdog cycle -> `done`, `timeout_err`=0.
4. `one_image_over` held high from before START -> no completion. Drop it and raise it again -> `done`.
5. `host_start` pulsed during RUN with `host_ratio`=5 -> ignored, `compression_ratio` unchanged. Force `bytes_written` near 0xFFFFFFFF with `write_en`=4'b1111 -> it saturates at 0xFFFFFFFF.
6. Async `rst` asserted mid-RUN -> all outputs at reset values immediately. After release -> `core_rst`=1 next edge, IDLE.
